// File: rtl/uart_block_streamer_pkg.sv
// Shared definitions for the UART word streamer: frame FSM encoding, ASCII constants,
// and the elaboration-time parameter legality check.
package uart_block_streamer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_LC_A = 8'h61;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  function automatic bit params_ok(input int word_w, input int baud_div);
    return (word_w >= 8) && (word_w % 8 == 0) && (baud_div >= 2);
  endfunction

endpackage

// File: rtl/uart_tx_frame.sv
// One 8N1 frame: start bit, 8 data bits LSB first, stop bit, each BAUD_DIV cycles; tx registered.
// A new byte is taken when idle or in the last stop-bit cycle, so frames can run back to back.
module uart_tx_frame
  import uart_block_streamer_pkg::*;
#(
  parameter int BAUD_DIV = 1250
) (
  input  logic       hwclk,
  input  logic       rstn,
  input  logic       start,
  input  logic [7:0] byte_dat,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam int BAUD_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);

  state_t           state;
  logic [BAUD_W-1:0] baud;
  logic [2:0]        bit_cnt;
  logic [7:0]        shreg;
  logic              baud_end;
  logic              load;

  assign baud_end   = (baud == BAUD_LAST);
  assign frame_done = (state == ST_STOP) && baud_end;
  assign load       = start && ((state == ST_IDLE) || frame_done);
  assign busy       = (state != ST_IDLE);

  always_ff @(posedge hwclk or negedge rstn) begin
    if (!rstn) begin
      state   <= ST_IDLE;
      baud    <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
    end else if (load) begin
      state   <= ST_START;
      baud    <= '0;
      bit_cnt <= '0;
      shreg   <= byte_dat;
      tx      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: tx <= 1'b1;
        ST_START: begin
          if (baud_end) begin
            baud  <= '0;
            state <= ST_DATA;
            tx    <= shreg[0];
            shreg <= {1'b0, shreg[7:1]};
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
        ST_DATA: begin
          if (baud_end) begin
            baud <= '0;
            if (bit_cnt == 3'd7) begin
              state <= ST_STOP;
              tx    <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx      <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
            end
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
        ST_STOP: begin
          // Reaching here with baud_end means no follow-on byte was offered.
          if (baud_end) begin
            baud  <= '0;
            state <= ST_IDLE;
            tx    <= 1'b1;
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_block_streamer.sv
// Serialises one WORD_W word as a run of UART chars (raw or hex, optional CR/LF); start bit the cycle after accept.
// Word takes chars*10*BAUD_DIV+1 cycles to done; in_ready is low for the whole word, so in_valid then is ignored.
module uart_block_streamer
  import uart_block_streamer_pkg::*;
#(
  parameter int WORD_W         = 512,
  parameter int BAUD_DIV       = 1250,
  parameter int HEX_MODE       = 0,
  parameter int APPEND_NL      = 0,
  parameter int MSB_BYTE_FIRST = 0
) (
  input  logic              hwclk,
  input  logic              rstn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int NBYTES     = WORD_W / 8;
  localparam int CPB        = (HEX_MODE != 0) ? 2 : 1;
  localparam int DATA_CHARS = NBYTES * CPB;
  localparam int CHARS      = DATA_CHARS + ((APPEND_NL != 0) ? 2 : 0);
  localparam int IDX_W      = $clog2(CHARS) + 1;

  if (!params_ok(WORD_W, BAUD_DIV)) begin : g_param_check
    $error("uart_block_streamer: WORD_W must be a multiple of 8 (>= 8) and BAUD_DIV >= 2");
  end

  // Char i of a word: hex chars come upper nibble first, CR/LF trail the data chars.
  function automatic logic [7:0] char_at(input logic [WORD_W-1:0] w, input logic [IDX_W-1:0] i);
    int         ci;
    int         bi;
    logic [7:0] b;
    logic [3:0] nib;
    ci = int'(i);
    if (ci >= DATA_CHARS) return (ci == DATA_CHARS) ? ASCII_CR : ASCII_LF;
    bi = ci / CPB;
    if (MSB_BYTE_FIRST != 0) bi = NBYTES - 1 - bi;
    b = 8'(w >> (8 * bi));
    if (HEX_MODE == 0) return b;
    nib = (ci % 2 == 0) ? b[7:4] : b[3:0];
    return (nib < 4'd10) ? (ASCII_ZERO + {4'h0, nib}) : (ASCII_LC_A + {4'h0, nib} - 8'd10);
  endfunction

  logic [WORD_W-1:0] data_q;
  logic [IDX_W-1:0]  idx;
  logic              accept;
  logic              more;
  logic              start;
  logic [7:0]        byte_dat;
  logic              frame_busy;
  logic              frame_done;

  assign accept   = in_valid && in_ready && !frame_busy;
  assign more     = (idx < IDX_W'(CHARS));
  assign start    = accept || (busy && frame_done && more);
  assign byte_dat = accept ? char_at(in_data, {IDX_W{1'b0}}) : char_at(data_q, idx);

  always_ff @(posedge hwclk or negedge rstn) begin
    if (!rstn) begin
      data_q   <= '0;
      idx      <= '0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        data_q   <= in_data;
        idx      <= IDX_W'(1);
        in_ready <= 1'b0;
        busy     <= 1'b1;
      end else if (busy && frame_done) begin
        if (more) begin
          idx <= idx + IDX_W'(1);
        end else begin
          idx      <= '0;
          busy     <= 1'b0;
          in_ready <= 1'b1;
          done     <= 1'b1;
        end
      end else if (!busy) begin
        in_ready <= 1'b1;
      end
    end
  end

  uart_tx_frame #(
    .BAUD_DIV(BAUD_DIV)
  ) u_frame (
    .hwclk     (hwclk),
    .rstn      (rstn),
    .start     (start),
    .byte_dat  (byte_dat),
    .tx        (tx),
    .busy      (frame_busy),
    .frame_done(frame_done)
  );

endmodule

// File: tb/tb_uart_block_streamer.sv
// Five parameterisations driven by directed words; per-instance UART receivers and done trackers
// pop expected chars and word durations from queues filled by the stimulus process.
module tb_uart_block_streamer;

  localparam int NI = 5;

  logic        hwclk;
  logic        rstn;
  logic        vld    [NI];
  logic [511:0] din   [NI];
  logic        rdy_w  [NI];
  logic        tx_w   [NI];
  logic        busy_w [NI];
  logic        done_w [NI];

  logic [7:0] exp_chr [NI][$];
  int         exp_dur [NI][$];

  int checks   = 0;
  int failures = 0;

  initial hwclk = 1'b0;
  always #5 hwclk = ~hwclk;

  uart_block_streamer #(.WORD_W(16), .BAUD_DIV(4), .HEX_MODE(0), .APPEND_NL(0), .MSB_BYTE_FIRST(0)) u0 (
    .hwclk(hwclk), .rstn(rstn), .in_valid(vld[0]), .in_ready(rdy_w[0]), .in_data(din[0][15:0]),
    .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0]));
  uart_block_streamer #(.WORD_W(16), .BAUD_DIV(4), .HEX_MODE(1), .APPEND_NL(0), .MSB_BYTE_FIRST(0)) u1 (
    .hwclk(hwclk), .rstn(rstn), .in_valid(vld[1]), .in_ready(rdy_w[1]), .in_data(din[1][15:0]),
    .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1]));
  uart_block_streamer #(.WORD_W(16), .BAUD_DIV(4), .HEX_MODE(1), .APPEND_NL(0), .MSB_BYTE_FIRST(1)) u2 (
    .hwclk(hwclk), .rstn(rstn), .in_valid(vld[2]), .in_ready(rdy_w[2]), .in_data(din[2][15:0]),
    .tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2]));
  uart_block_streamer #(.WORD_W(8), .BAUD_DIV(4), .HEX_MODE(0), .APPEND_NL(1), .MSB_BYTE_FIRST(0)) u3 (
    .hwclk(hwclk), .rstn(rstn), .in_valid(vld[3]), .in_ready(rdy_w[3]), .in_data(din[3][7:0]),
    .tx(tx_w[3]), .busy(busy_w[3]), .done(done_w[3]));
  uart_block_streamer #(.WORD_W(512), .BAUD_DIV(2), .HEX_MODE(0), .APPEND_NL(0), .MSB_BYTE_FIRST(0)) u4 (
    .hwclk(hwclk), .rstn(rstn), .in_valid(vld[4]), .in_ready(rdy_w[4]), .in_data(din[4]),
    .tx(tx_w[4]), .busy(busy_w[4]), .done(done_w[4]));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h", nm, act, req);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_mon
    localparam int BD = (g == 4) ? 2 : 4;

    // Receiver: samples each bit mid-period, aborts a frame that reset cuts short.
    initial begin : rx
      logic [9:0] bits;
      logic [7:0] e;
      bit         ok;
      forever begin
        @(negedge hwclk);
        if (rstn === 1'b1 && tx_w[g] === 1'b0) begin
          ok   = 1'b1;
          bits = '0;
          for (int n = 0; n < 10 * BD; n++) begin
            if (n != 0) @(negedge hwclk);
            if (rstn !== 1'b1) begin
              ok = 1'b0;
              break;
            end
            if (n % BD == BD / 2) bits[n / BD] = tx_w[g];
          end
          if (ok) begin
            if (exp_chr[g].size() == 0) begin
              checks++;
              failures++;
              $display("FAIL unexpected_char u%0d: got %02h, want no frame", g, bits[8:1]);
            end else begin
              e = exp_chr[g].pop_front();
              chk($sformatf("frame u%0d", g), 64'(bits), 64'({1'b1, e, 1'b0}));
            end
          end
        end
      end
    end

    // Word tracker: cycle 0 is the accept cycle; start bit must show in cycle 1.
    initial begin : dm
      int n;
      bit trk;
      trk = 1'b0;
      n   = 0;
      forever begin
        @(negedge hwclk);
        if (rstn !== 1'b1) begin
          trk = 1'b0;
        end else begin
          if (trk) n++;
          if (trk && n == 1) chk($sformatf("start_bit_cycle1 u%0d", g), 64'(tx_w[g]), 64'd0);
          if (done_w[g] === 1'b1) begin
            if (!trk || exp_dur[g].size() == 0) begin
              checks++;
              failures++;
              $display("FAIL spurious_done u%0d: got done=1, want 0", g);
            end else begin
              chk($sformatf("word_cycles u%0d", g), 64'(n), 64'(exp_dur[g].pop_front()));
              chk($sformatf("done_rdy_busy u%0d", g), 64'({rdy_w[g], busy_w[g]}), 64'b10);
            end
            trk = 1'b0;
          end
          if (vld[g] === 1'b1 && rdy_w[g] === 1'b1) begin
            trk = 1'b1;
            n   = 0;
          end
        end
      end
    end
  end

  task automatic wait_rdy(input int k);
    int t = 0;
    while (rdy_w[k] !== 1'b1 && t < 3000) begin
      @(posedge hwclk);
      #2;
      t++;
    end
    if (t >= 3000) begin
      checks++;
      failures++;
      $display("FAIL wait_rdy u%0d: in_ready=%b after %0d cycles, want 1", k, rdy_w[k], t);
    end
  endtask

  task automatic send(input int k, input logic [511:0] d);
    wait_rdy(k);
    vld[k] = 1'b1;
    din[k] = d;
    @(posedge hwclk);
    #2;
    vld[k] = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [511:0] big;
    rstn = 1'b0;
    for (int k = 0; k < NI; k++) begin
      vld[k] = 1'b0;
      din[k] = '0;
    end
    repeat (2) @(posedge hwclk);
    #2;
    for (int k = 0; k < NI; k++)
      chk($sformatf("reset_state u%0d", k), 64'({tx_w[k], rdy_w[k], busy_w[k], done_w[k]}), 64'b1000);
    rstn = 1'b1;
    #1;
    chk("rdy_before_first_edge", 64'(rdy_w[0]), 64'd0);
    @(posedge hwclk);
    #2;
    chk("rdy_after_first_edge", 64'(rdy_w[0]), 64'd1);

    // Raw word, then a busy-time pulse that must be ignored, then a held word taken right after done.
    exp_chr[0].push_back(8'h5A); exp_chr[0].push_back(8'hA5); exp_dur[0].push_back(81);
    send(0, 512'h A55A);
    repeat (10) @(posedge hwclk);
    #2;
    vld[0] = 1'b1;
    din[0] = 512'h FFFF;
    repeat (2) @(posedge hwclk);
    #2;
    din[0] = 512'h 0102;
    exp_chr[0].push_back(8'h02); exp_chr[0].push_back(8'h01); exp_dur[0].push_back(81);
    wait_rdy(0);
    @(posedge hwclk);
    #2;
    vld[0] = 1'b0;
    exp_chr[0].push_back(8'hFF); exp_chr[0].push_back(8'h00); exp_dur[0].push_back(81);
    send(0, 512'h 00FF);

    // Hex, LSB byte first.
    exp_chr[1].push_back(8'h30); exp_chr[1].push_back(8'h63);
    exp_chr[1].push_back(8'h33); exp_chr[1].push_back(8'h66); exp_dur[1].push_back(161);
    send(1, 512'h 3F0C);
    exp_chr[1].push_back(8'h62); exp_chr[1].push_back(8'h35);
    exp_chr[1].push_back(8'h61); exp_chr[1].push_back(8'h39); exp_dur[1].push_back(161);
    send(1, 512'h A9B5);
    exp_chr[1].push_back(8'h66); exp_chr[1].push_back(8'h61);
    exp_chr[1].push_back(8'h30); exp_chr[1].push_back(8'h39); exp_dur[1].push_back(161);
    send(1, 512'h 09FA);

    // Hex, MSB byte first.
    exp_chr[2].push_back(8'h33); exp_chr[2].push_back(8'h66);
    exp_chr[2].push_back(8'h30); exp_chr[2].push_back(8'h63); exp_dur[2].push_back(161);
    send(2, 512'h 3F0C);

    // Single byte with CR/LF.
    exp_chr[3].push_back(8'h41); exp_chr[3].push_back(8'h0D);
    exp_chr[3].push_back(8'h0A); exp_dur[3].push_back(121);
    send(3, 512'h 41);
    exp_chr[3].push_back(8'h00); exp_chr[3].push_back(8'h0D);
    exp_chr[3].push_back(8'h0A); exp_dur[3].push_back(121);
    send(3, 512'h 00);

    // Full 512-bit word, byte i = i.
    big = '0;
    for (int i = 0; i < 64; i++) begin
      big[8*i +: 8] = 8'(i);
      exp_chr[4].push_back(8'(i));
    end
    exp_dur[4].push_back(1281);
    send(4, big);

    for (int k = 0; k < NI; k++) wait_rdy(k);
    repeat (5) @(posedge hwclk);
    #2;

    // Reset in the middle of data bit 3 of 0x34 (bit value 0): word abandoned, no done.
    send(0, 512'h 1234);
    repeat (17) @(posedge hwclk);
    #2;
    chk("pre_reset_bit3", 64'(tx_w[0]), 64'd0);
    rstn = 1'b0;
    #1;
    chk("async_reset_outputs", 64'({tx_w[0], rdy_w[0], busy_w[0], done_w[0]}), 64'b1000);
    repeat (3) @(posedge hwclk);
    #2;
    rstn = 1'b1;
    #1;
    chk("rdy_after_release", 64'(rdy_w[0]), 64'd0);
    @(posedge hwclk);
    #2;
    chk("rdy_edge_after_release", 64'(rdy_w[0]), 64'd1);
    exp_chr[0].push_back(8'h01); exp_chr[0].push_back(8'h00); exp_dur[0].push_back(81);
    send(0, 512'h 0001);
    wait_rdy(0);
    repeat (5) @(posedge hwclk);
    #2;

    for (int k = 0; k < NI; k++) begin
      chk($sformatf("chars_left u%0d", k), 64'(exp_chr[k].size()), 64'd0);
      chk($sformatf("dones_left u%0d", k), 64'(exp_dur[k].size()), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
